circuito_jogo_param: RTL and testbench
======================================

CIRCUITO_JOGO_PARAM -- requirements
Module: circuito_jogo_param

Interface
REQ-001 The block SHALL expose parameter N_CHAVES, default 4, meaning the switch/LED width.
REQ-002 The block SHALL expose parameter DEPTH, default 16, meaning the number of stored plays (power of 2, at least 2).
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 5000, meaning the cycles allowed per play (5 s at 1 kHz).
REQ-004 The block SHALL have a single clock, port clock, input, 1 bit, rising-edge.
REQ-005 The block SHALL have reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have the following ports:
- iniciar: input, 1 bit, start/restart request.
- nivel: input, 1 bit; 0 = DEPTH/2 rounds, 1 = DEPTH rounds; sampled at start.
- chaves: input, N_CHAVES bits, player switches.
- acertou, errou, pronto, timeout: output, 1 bit each, result flags.
- leds: output, N_CHAVES bits, last registered play.
- db_estado: output, 4 bits, FSM state code.
- db_contagem: output, clog2(DEPTH) bits, current address.
- db_igual: output, 1 bit, compare result.
- db_jogada_feita: output, 1 bit, play-detect pulse.

Function
REQ-007 The stored value at address i SHALL be one-hot bit (i mod N_CHAVES).
REQ-008 A play SHALL be detected as a one-cycle db_jogada_feita pulse when chaves is nonzero and the chaves value registered one cycle earlier was zero; holding chaves nonzero SHALL NOT retrigger.
REQ-009 The FSM SHALL use these state codes: INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=3, COMPARA=4, PROXIMO=5, FIM_ACERTO=6, FIM_ERRO=7, FIM_TIMEOUT=8.
REQ-010 INICIAL->PREPARA on iniciar=1. PREPARA SHALL clear the address, jogada register and timeout counter, latch nivel, then go to ESPERA.
REQ-011 In ESPERA, the timeout counter SHALL increment every cycle. The next state SHALL be REGISTRA on db_jogada_feita, otherwise FIM_TIMEOUT when the counter equals TIMEOUT_CYCLES-1.
REQ-012 If a play is detected on the same cycle the limit is reached, the play SHALL win.
REQ-013 REGISTRA SHALL load chaves into the jogada register, so leds updates on the next edge.
REQ-014 COMPARA SHALL evaluate db_igual = (jogada == stored value at address). The next state SHALL be:
- FIM_ERRO if db_igual=0;
- FIM_ACERTO if db_igual=1 and the address is the last round (DEPTH/2-1 or DEPTH-1 per latched nivel);
- PROXIMO otherwise.
REQ-015 PROXIMO SHALL increment the address, clear the timeout counter, and return to ESPERA.
REQ-016 A play whose chaves value is not one-hot SHALL be compared as-is and therefore SHALL produce FIM_ERRO.
REQ-017 acertou, errou and timeout SHALL be 1 only in FIM_ACERTO, FIM_ERRO and FIM_TIMEOUT respectively. pronto SHALL be 1 in all three final states. Outputs SHALL be Moore and registered through the state.
REQ-018 Final states SHALL hold until iniciar=1, then go to PREPARA.
REQ-019 iniciar SHALL be ignored in PREPARA through PROXIMO.
REQ-020 Play-detect latency SHALL be two cycles from the chaves edge to entering COMPARA, with the result state one cycle later.

Reset
REQ-021 reset=1 at a rising edge SHALL force INICIAL, address 0, jogada 0, timeout counter 0, registered chaves 0, and latched nivel 0 in any state, including mid-game.
REQ-022 After reset, all outputs SHALL be 0 and db_estado SHALL be 0.
REQ-023 reset SHALL take priority over iniciar and over play detection.

Structure
REQ-024 State codes and the default parameter values SHALL live in shared package jogo_pkg.
REQ-025 The stored-play memory SHALL be sub-module rom_jogadas: combinational read, parameters N_CHAVES and DEPTH, contents per REQ-007.
REQ-026 The edge detector, counters, and FSM SHALL reside in circuito_jogo_param.

Verification
All scenarios use N_CHAVES=4, DEPTH=16, TIMEOUT_CYCLES=20, unless stated.
REQ-027 Reset, then idle 10 cycles -> pronto=acertou=errou=timeout=0, db_estado=0.
REQ-028 iniciar 5 cycles with nivel=0, then plays 0001,0010,0100,1000,0001,0010,0100,1000, each held 10 cycles with 10 zero cycles between -> acertou=1, pronto=1, db_estado=6, db_contagem=7.
REQ-029 iniciar, play 0001, then play 0100 -> errou=1, leds=0100, db_contagem=1, db_estado=7.
REQ-030 iniciar, play 0001, then no play for 25 cycles -> timeout=1, pronto=1, db_estado=8, with timeout asserted exactly 20 cycles after ESPERA entry.
REQ-031 chaves=0001 held 30 cycles after start -> exactly one db_jogada_feita pulse.
REQ-032 Reset asserted during ESPERA at address 3 -> db_estado=0 and db_contagem=0 next cycle; then iniciar with nivel=1 and 16 correct plays -> acertou=1.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game controller.
// Holds the default parameter values and the FSM state codes, so the
// top level and its bench agree on one encoding of db_estado.
package jogo_pkg;

    localparam int N_CHAVES_DEF       = 4;
    localparam int DEPTH_DEF          = 16;
    localparam int TIMEOUT_CYCLES_DEF = 5000;

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] PREPARA     = 4'd1;
    localparam logic [3:0] ESPERA      = 4'd2;
    localparam logic [3:0] REGISTRA    = 4'd3;
    localparam logic [3:0] COMPARA     = 4'd4;
    localparam logic [3:0] PROXIMO     = 4'd5;
    localparam logic [3:0] FIM_ACERTO  = 4'd6;
    localparam logic [3:0] FIM_ERRO    = 4'd7;
    localparam logic [3:0] FIM_TIMEOUT = 4'd8;

endpackage

// File: rtl/rom_jogadas.sv
// Stored-play memory for the game.
// The sequence is fixed: address i holds a one-hot word with bit
// (i mod N_CHAVES) set, so the expected plays walk across the switches.
// Ports:
//   endereco : read address, clog2(DEPTH) bits
//   dado     : expected play at that address, N_CHAVES bits (combinational)
module rom_jogadas
    import jogo_pkg::*;
#(
    parameter int N_CHAVES = N_CHAVES_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic [$clog2(DEPTH)-1:0] endereco,
    output logic [N_CHAVES-1:0]      dado
);

    assign dado = N_CHAVES'(1) << (int'(endereco) % N_CHAVES);

endmodule

// File: rtl/circuito_jogo_param.sv
// Memory game controller: the player must repeat the stored sequence of
// one-hot plays on the switches, one play per round, within a time limit.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   iniciar             : start / restart request
//   nivel               : 0 = DEPTH/2 rounds, 1 = DEPTH rounds (latched at start)
//   chaves              : player switches
//   acertou, errou,
//   timeout, pronto     : result flags (Moore, decoded from the state register)
//   leds                : last registered play
//   db_estado           : current state code
//   db_contagem         : current round address
//   db_igual            : registered play equals stored play at current address
//   db_jogada_feita     : one-cycle pulse on a zero -> nonzero switch edge
//
// state        | meaning
// INICIAL      | idle after reset, waiting for iniciar
// PREPARA      | clear address, play register and timer; latch nivel
// ESPERA       | timer running, waiting for a play
// REGISTRA     | capture switches into the play register
// COMPARA      | compare captured play with the stored one
// PROXIMO      | advance to the next round, restart the timer
// FIM_ACERTO   | all rounds correct
// FIM_ERRO     | wrong play
// FIM_TIMEOUT  | no play within the time limit
module circuito_jogo_param
    import jogo_pkg::*;
#(
    parameter int N_CHAVES       = N_CHAVES_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     nivel,
    input  logic [N_CHAVES-1:0]      chaves,
    output logic                     acertou,
    output logic                     errou,
    output logic                     pronto,
    output logic                     timeout,
    output logic [N_CHAVES-1:0]      leds,
    output logic [3:0]               db_estado,
    output logic [$clog2(DEPTH)-1:0] db_contagem,
    output logic                     db_igual,
    output logic                     db_jogada_feita
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0] ULTIMO_FACIL   = AW'(DEPTH / 2 - 1);
    localparam logic [AW-1:0] ULTIMO_DIFICIL = AW'(DEPTH - 1);
    localparam logic [TW-1:0] LIMITE         = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]          estado;
    logic [3:0]          proximo_estado;
    logic [AW-1:0]       endereco;
    logic [N_CHAVES-1:0] jogada;
    logic [N_CHAVES-1:0] chaves_reg;
    logic [N_CHAVES-1:0] dado_rom;
    logic [TW-1:0]       tempo;
    logic                nivel_reg;
    logic                jogada_feita;
    logic                igual;
    logic [AW-1:0]       ultimo;

    rom_jogadas #(
        .N_CHAVES (N_CHAVES),
        .DEPTH    (DEPTH)
    ) u_rom (
        .endereco (endereco),
        .dado     (dado_rom)
    );

    // Only the first nonzero value after an all-zero cycle counts as a play,
    // so holding the switches down never starts a second round.
    assign jogada_feita = (chaves != '0) && (chaves_reg == '0);
    assign igual        = (jogada == dado_rom);
    assign ultimo       = nivel_reg ? ULTIMO_DIFICIL : ULTIMO_FACIL;

    always_comb begin
        proximo_estado = estado;
        case (estado)
            INICIAL:  if (iniciar) proximo_estado = PREPARA;
            PREPARA:  proximo_estado = ESPERA;
            // A play on the same cycle the limit is hit still counts.
            ESPERA: begin
                if (jogada_feita)
                    proximo_estado = REGISTRA;
                else if (tempo == LIMITE)
                    proximo_estado = FIM_TIMEOUT;
            end
            REGISTRA: proximo_estado = COMPARA;
            COMPARA: begin
                if (!igual)
                    proximo_estado = FIM_ERRO;
                else if (endereco == ultimo)
                    proximo_estado = FIM_ACERTO;
                else
                    proximo_estado = PROXIMO;
            end
            PROXIMO:  proximo_estado = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                if (iniciar) proximo_estado = PREPARA;
            default:  proximo_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            endereco   <= '0;
            jogada     <= '0;
            tempo      <= '0;
            chaves_reg <= '0;
            nivel_reg  <= 1'b0;
        end else begin
            estado     <= proximo_estado;
            chaves_reg <= chaves;
            case (estado)
                PREPARA: begin
                    endereco  <= '0;
                    jogada    <= '0;
                    tempo     <= '0;
                    nivel_reg <= nivel;
                end
                ESPERA:   tempo <= tempo + TW'(1);
                REGISTRA: jogada <= chaves;
                PROXIMO: begin
                    endereco <= endereco + AW'(1);
                    tempo    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign acertou         = (estado == FIM_ACERTO);
    assign errou           = (estado == FIM_ERRO);
    assign timeout         = (estado == FIM_TIMEOUT);
    assign pronto          = acertou || errou || timeout;
    assign leds            = jogada;
    assign db_estado       = estado;
    assign db_contagem     = endereco;
    assign db_igual        = igual;
    assign db_jogada_feita = jogada_feita;

endmodule

// File: tb/tb_circuito_jogo_param.sv
module tb_circuito_jogo_param;

    localparam int NC = 4;
    localparam int DP = 16;
    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       nivel;
    logic [3:0] chaves;
    logic       acertou, errou, pronto, timeout;
    logic [3:0] leds;
    logic [3:0] db_estado;
    logic [3:0] db_contagem;
    logic       db_igual, db_jogada_feita;

    circuito_jogo_param #(
        .N_CHAVES       (NC),
        .DEPTH          (DP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .nivel           (nivel),
        .chaves          (chaves),
        .acertou         (acertou),
        .errou           (errou),
        .pronto          (pronto),
        .timeout         (timeout),
        .leds            (leds),
        .db_estado       (db_estado),
        .db_contagem     (db_contagem),
        .db_igual        (db_igual),
        .db_jogada_feita (db_jogada_feita)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       nv;
        int         n_good;
        logic [3:0] bad;
        int         est;
        int         cnt;
        int         led;
    } vec_t;

    vec_t       tabela[8];
    logic [3:0] seq_q[$];

    task automatic check(input string nome, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nome, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_game(input logic nv);
        nivel   = nv;
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(1);
    endtask

    task automatic play(input logic [3:0] v, input int hold, input int gap);
        chaves = v;
        tick(hold);
        chaves = 4'h0;
        tick(gap);
    endtask

    task automatic wait_pronto(input int budget, input string nome);
        int k;
        k = 0;
        while (!pronto && k < budget) begin
            tick(1);
            k++;
        end
        check(nome, int'(pronto), 1);
    endtask

    task automatic run_game(input logic nv);
        start_game(nv);
        foreach (seq_q[i]) begin
            if (pronto) break;
            play(seq_q[i], 5, 6);
        end
        wait_pronto(60, "fim_de_jogo");
    endtask

    // Reference: walk the rounds; the first wrong play ends in error, running
    // out of plays ends in timeout, matching the last round ends in success.
    task automatic modelo(input logic nv, output int est, output int cnt, output int led);
        int rounds;
        logic [3:0] one;
        rounds = nv ? DP : DP / 2;
        est = 8; cnt = 0; led = 0;
        for (int i = 0; i < rounds; i++) begin
            if (i >= seq_q.size()) begin
                est = 8; cnt = i; return;
            end
            led = int'(seq_q[i]);
            one = 4'(1 << (i % NC));
            if (seq_q[i] != one) begin
                est = 7; cnt = i; return;
            end
            if (i == rounds - 1) begin
                est = 6; cnt = i; return;
            end
        end
    endtask

    task automatic check_final(input string tag, input int est, input int cnt, input int led);
        check({tag, "_estado"},   int'(db_estado), est);
        check({tag, "_contagem"}, int'(db_contagem), cnt);
        check({tag, "_leds"},     int'(leds), led);
        check({tag, "_acertou"},  int'(acertou), int'(est == 6));
        check({tag, "_errou"},    int'(errou), int'(est == 7));
        check({tag, "_timeout"},  int'(timeout), int'(est == 8));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int est, cnt, led;
        logic nv;
        int rounds;

        tabela[0] = '{1'b0, 8,  4'h0, 6, 7,  8};
        tabela[1] = '{1'b0, 1,  4'h4, 7, 1,  4};
        tabela[2] = '{1'b0, 0,  4'h3, 7, 0,  3};
        tabela[3] = '{1'b0, 2,  4'h0, 8, 2,  2};
        tabela[4] = '{1'b1, 16, 4'h0, 6, 15, 8};
        tabela[5] = '{1'b1, 9,  4'h1, 7, 9,  1};
        tabela[6] = '{1'b0, 0,  4'h0, 8, 0,  0};
        tabela[7] = '{1'b1, 3,  4'hF, 7, 3,  15};

        reset = 1'b1; iniciar = 1'b0; nivel = 1'b0; chaves = 4'h0;
        tick(3);
        reset = 1'b0;
        tick(10);
        check("rst_pronto",  int'(pronto), 0);
        check("rst_acertou", int'(acertou), 0);
        check("rst_errou",   int'(errou), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_estado",  int'(db_estado), 0);
        check("rst_contagem", int'(db_contagem), 0);
        check("rst_leds",    int'(leds), 0);
        check("rst_igual",   int'(db_igual), 0);
        check("rst_pulso",   int'(db_jogada_feita), 0);

        // reset beats iniciar
        reset = 1'b1; iniciar = 1'b1;
        tick(1);
        check("rst_prio_estado", int'(db_estado), 0);
        reset = 1'b0; iniciar = 1'b0;
        tick(1);
        check("rst_prio_idle", int'(db_estado), 0);

        // full easy game, iniciar held 5 cycles
        nivel = 1'b0; iniciar = 1'b1;
        tick(5);
        iniciar = 1'b0;
        for (int i = 0; i < 8; i++) play(4'(1 << (i % NC)), 10, 10);
        check("facil_acertou", int'(acertou), 1);
        check("facil_pronto",  int'(pronto), 1);
        check("facil_estado",  int'(db_estado), 6);
        check("facil_contagem", int'(db_contagem), 7);

        // wrong second play
        start_game(1'b0);
        play(4'h1, 5, 6);
        play(4'h4, 5, 6);
        check("erro_errou",    int'(errou), 1);
        check("erro_leds",     int'(leds), 4);
        check("erro_contagem", int'(db_contagem), 1);
        check("erro_estado",   int'(db_estado), 7);

        // detect latency, then exact timeout timing
        start_game(1'b0);
        check("espera_entrada", int'(db_estado), 2);
        chaves = 4'h1;
        #1;
        check("pulso_visivel", int'(db_jogada_feita), 1);
        tick(1);
        check("lat_registra", int'(db_estado), 3);
        check("pulso_unico",  int'(db_jogada_feita), 0);
        tick(1);
        check("lat_compara",  int'(db_estado), 4);
        tick(1);
        check("lat_proximo",  int'(db_estado), 5);
        tick(1);
        check("reentra_espera", int'(db_estado), 2);
        chaves = 4'h0;
        tick(19);
        check("to_ainda_espera", int'(db_estado), 2);
        check("to_ainda_zero",   int'(timeout), 0);
        tick(1);
        check("to_estado",  int'(db_estado), 8);
        check("to_timeout", int'(timeout), 1);
        check("to_pronto",  int'(pronto), 1);

        // holding switches yields one pulse
        start_game(1'b0);
        chaves = 4'h1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (db_jogada_feita) pulses++;
            tick(1);
        end
        chaves = 4'h0;
        check("pulsos_segurando", pulses, 1);

        // reset mid-game, then a hard game
        start_game(1'b0);
        play(4'h1, 5, 6);
        play(4'h2, 5, 6);
        play(4'h4, 5, 6);
        check("meio_estado",   int'(db_estado), 2);
        check("meio_contagem", int'(db_contagem), 3);
        reset = 1'b1;
        tick(1);
        check("meio_rst_estado",   int'(db_estado), 0);
        check("meio_rst_contagem", int'(db_contagem), 0);
        check("meio_rst_leds",     int'(leds), 0);
        reset = 1'b0;
        seq_q.delete();
        for (int i = 0; i < DP; i++) seq_q.push_back(4'(1 << (i % NC)));
        run_game(1'b1);
        check("dificil_acertou",  int'(acertou), 1);
        check("dificil_contagem", int'(db_contagem), 15);

        // directed table
        for (int t = 0; t < 8; t++) begin
            seq_q.delete();
            for (int j = 0; j < tabela[t].n_good; j++) seq_q.push_back(4'(1 << (j % NC)));
            if (tabela[t].bad != 4'h0) seq_q.push_back(tabela[t].bad);
            run_game(tabela[t].nv);
            check_final($sformatf("tab%0d", t), tabela[t].est, tabela[t].cnt, tabela[t].led);
        end

        // random games against the model
        for (int g = 0; g < 25; g++) begin
            nv = 1'($urandom_range(0, 1));
            rounds = nv ? DP : DP / 2;
            seq_q.delete();
            for (int i = 0; i < rounds; i++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r == 0) break;
                else if (r < 3) seq_q.push_back(4'($urandom_range(1, 15)));
                else seq_q.push_back(4'(1 << (i % NC)));
            end
            modelo(nv, est, cnt, led);
            run_game(nv);
            check_final($sformatf("rnd%0d", g), est, cnt, led);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
